// File: rtl/sr_imem_loader_pkg.sv
// Shared constants for the schoolRISCV instruction-memory loader.
// Provides the 3-bit loader state encodings, the default frame sync byte,
// payload widths and a helper that classifies "frame in progress" states.
package sr_imem_loader_pkg;

   localparam int unsigned LDR_WORD_W = 32;
   localparam int unsigned LDR_LEN_W  = 16;
   localparam int unsigned LDR_ST_W   = 3;

   localparam logic [LDR_ST_W-1:0] LDR_ST_IDLE   = 3'd0;
   localparam logic [LDR_ST_W-1:0] LDR_ST_LEN_LO = 3'd1;
   localparam logic [LDR_ST_W-1:0] LDR_ST_LEN_HI = 3'd2;
   localparam logic [LDR_ST_W-1:0] LDR_ST_DATA   = 3'd3;
   localparam logic [LDR_ST_W-1:0] LDR_ST_WRITE  = 3'd4;
   localparam logic [LDR_ST_W-1:0] LDR_ST_RUN    = 3'd5;

   localparam logic [7:0] LDR_SYNC_BYTE = 8'hA5;

   // A frame is in progress from the first length byte through the RAM write.
   function automatic logic ldrStIsBusy(input logic [LDR_ST_W-1:0] st);
      return (st == LDR_ST_LEN_LO) || (st == LDR_ST_LEN_HI) ||
             (st == LDR_ST_DATA)   || (st == LDR_ST_WRITE);
   endfunction

endpackage

// File: rtl/sr_imem_loader_ram.sv
// Instruction RAM: 2**ADDR_WIDTH x DATA_WIDTH, synchronous write, asynchronous read.
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write word address
//   wdata  - write data
//   raddr  - read word address
//   rdata  - read data (combinational; returns old data during a same-cycle write)
module sr_imem_ram #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Contents deliberately survive reset so a reset mid-load keeps earlier words.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sr_imem_loader.sv
// Instruction-memory front end for the schoolRISCV core.
// Parses a byte stream of frames {SYNC, LEN_LO, LEN_HI, N x 4-byte LE words},
// writes the words into the instruction RAM and holds the core in reset until
// a complete program has been written.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   rx_valid/rx_data/rx_ready - byte stream handshake (transfer on valid & ready)
//   imAddr/imData - core fetch port (word address, combinational read)
//   cpu_rst_n     - core reset, active-low, high only in RUN
//   busy          - frame in progress
//   error         - sticky frame error, cleared by the next accepted sync byte
//   words_loaded  - words written in the current/last frame
module sr_imem_loader
   import sr_imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter logic [7:0]  SYNC_BYTE  = LDR_SYNC_BYTE,
   parameter int unsigned TIMEOUT    = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   input  logic [31:0] imAddr,
   output logic [31:0] imData,
   output logic        cpu_rst_n,
   output logic        busy,
   output logic        error,
   output logic [15:0] words_loaded
);

   localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
   localparam int unsigned IDLE_W    = $clog2(TIMEOUT);
   localparam int unsigned WL_W      = ADDR_WIDTH + 1;
   localparam int unsigned LEN_EXT_W = LDR_LEN_W + 1;

   localparam logic [IDLE_W-1:0]    IDLE_LAST = IDLE_W'(TIMEOUT - 1);
   localparam logic [LEN_EXT_W-1:0] MAX_LEN   = LEN_EXT_W'(DEPTH);

   logic [LDR_ST_W-1:0]   state, stateNext;
   logic [7:0]            lenLo, lenLoNext;
   logic [LDR_LEN_W-1:0]  lenN, lenNNext;
   logic [ADDR_WIDTH-1:0] wptr, wptrNext;
   logic [1:0]            bidx, bidxNext;
   logic [LDR_WORD_W-1:0] word, wordNext;
   logic [IDLE_W-1:0]     idleCnt, idleNext;
   logic [WL_W-1:0]       wordsLoaded, wlNext;
   logic                  errorQ, errorNext;
   logic                  rxReadyQ, busyQ, cpuRstNQ;

   logic                  accept_c;
   logic                  isSync_c;
   logic [LDR_LEN_W-1:0]  lenVal_c;
   logic                  lenBad_c;
   logic                  lastWord_c;
   logic                  counting_c;
   logic                  memWe_c;
   logic                  unusedImAddr_c;

   assign accept_c   = rx_valid & rxReadyQ;
   assign isSync_c   = (rx_data == SYNC_BYTE);
   assign lenVal_c   = {rx_data, lenLo};
   assign lenBad_c   = (lenVal_c == '0) || ({1'b0, lenVal_c} > MAX_LEN);
   assign lastWord_c = (LDR_LEN_W'(wptr) == (lenN - LDR_LEN_W'(1)));
   assign counting_c = (state == LDR_ST_LEN_LO) || (state == LDR_ST_LEN_HI) ||
                       (state == LDR_ST_DATA);
   assign memWe_c    = (state == LDR_ST_WRITE);

   // Upper fetch-address bits are ignored; the RAM image wraps.
   assign unusedImAddr_c = ^imAddr[31:ADDR_WIDTH];

   sr_imem_ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (LDR_WORD_W)
   ) uRam (
      .clk   (clk),
      .we    (memWe_c),
      .waddr (wptr),
      .wdata (word),
      .raddr (imAddr[ADDR_WIDTH-1:0]),
      .rdata (imData)
   );

   // Next-state and datapath update.
   always_comb begin
      stateNext = state;
      lenLoNext = lenLo;
      lenNNext  = lenN;
      wptrNext  = wptr;
      bidxNext  = bidx;
      wordNext  = word;
      wlNext    = wordsLoaded;
      errorNext = errorQ;
      idleNext  = '0;

      case (state)
         LDR_ST_IDLE, LDR_ST_RUN: begin
            if (accept_c && isSync_c) begin
               stateNext = LDR_ST_LEN_LO;
               errorNext = 1'b0;
            end
         end
         LDR_ST_LEN_LO: begin
            if (accept_c) begin
               lenLoNext = rx_data;
               stateNext = LDR_ST_LEN_HI;
            end
         end
         LDR_ST_LEN_HI: begin
            if (accept_c) begin
               if (lenBad_c) begin
                  stateNext = LDR_ST_IDLE;
                  errorNext = 1'b1;
               end else begin
                  lenNNext  = lenVal_c;
                  wptrNext  = '0;
                  bidxNext  = '0;
                  wlNext    = '0;
                  stateNext = LDR_ST_DATA;
               end
            end
         end
         LDR_ST_DATA: begin
            // Little-endian: each byte enters at the top and shifts down.
            if (accept_c) begin
               wordNext = {rx_data, word[LDR_WORD_W-1:8]};
               bidxNext = bidx + 2'd1;
               if (bidx == 2'd3) begin
                  stateNext = LDR_ST_WRITE;
               end
            end
         end
         LDR_ST_WRITE: begin
            wlNext = wordsLoaded + WL_W'(1);
            if (lastWord_c) begin
               stateNext = LDR_ST_RUN;
            end else begin
               wptrNext  = wptr + ADDR_WIDTH'(1);
               stateNext = LDR_ST_DATA;
            end
         end
         default: begin
            stateNext = LDR_ST_IDLE;
         end
      endcase

      // Mid-frame inactivity watchdog; any accepted byte restarts it.
      if (counting_c && !accept_c) begin
         if (idleCnt == IDLE_LAST) begin
            stateNext = LDR_ST_IDLE;
            errorNext = 1'b1;
         end else begin
            idleNext = idleCnt + IDLE_W'(1);
         end
      end
   end

   // State and datapath registers; status outputs are registered from stateNext.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= LDR_ST_IDLE;
         lenLo       <= '0;
         lenN        <= '0;
         wptr        <= '0;
         bidx        <= '0;
         word        <= '0;
         idleCnt     <= '0;
         wordsLoaded <= '0;
         errorQ      <= 1'b0;
         rxReadyQ    <= 1'b1;
         busyQ       <= 1'b0;
         cpuRstNQ    <= 1'b0;
      end else begin
         state       <= stateNext;
         lenLo       <= lenLoNext;
         lenN        <= lenNNext;
         wptr        <= wptrNext;
         bidx        <= bidxNext;
         word        <= wordNext;
         idleCnt     <= idleNext;
         wordsLoaded <= wlNext;
         errorQ      <= errorNext;
         rxReadyQ    <= (stateNext != LDR_ST_WRITE);
         busyQ       <= ldrStIsBusy(stateNext);
         cpuRstNQ    <= (stateNext == LDR_ST_RUN);
      end
   end

   assign rx_ready     = rxReadyQ;
   assign busy         = busyQ;
   assign error        = errorQ;
   assign cpu_rst_n    = cpuRstNQ;
   assign words_loaded = 16'(wordsLoaded);

endmodule
